// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth digit streamer.
package booth_pkg;

  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } booth_digit_t;

  localparam logic [1:0] MAG_ZERO = 2'b00;
  localparam logic [1:0] MAG_ONE  = 2'b01;
  localparam logic [1:0] MAG_TWO  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int digit_count(input int width, input logic radix4);
    return radix4 ? (width / 2) : width;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Booth window encoder: {b2,b1,b0} -> -2*b2 + b1 + b0 as sign/magnitude.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  always_comb begin
    digit = '0;
    case (win)
      3'b001, 3'b010: digit.mag = MAG_ONE;
      3'b011:         digit.mag = MAG_TWO;
      3'b100: begin
        digit.neg = 1'b1;
        digit.mag = MAG_TWO;
      end
      3'b101, 3'b110: begin
        digit.neg = 1'b1;
        digit.mag = MAG_ONE;
      end
      default: digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_digit_streamer.sv
// Streams the Booth digits of one operand, LANES digits per beat, radix-2 or radix-4.
// Optional ZERO_SKIP_EN: all-zero non-last beats are dropped internally.
//   state   | meaning
//   ST_IDLE | no operand held, in_ready = 1
//   ST_RUN  | operand held, a beat is presented (or skipped) each cycle
module booth_digit_streamer
  import booth_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_m,
  input  logic               in_radix4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_neg,
  output logic [2*LANES-1:0] out_mag,
  output logic [LANES-1:0]   out_lane_en,
  output logic [IDXW-1:0]    out_idx,
  output logic               out_last
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               radix4_q, radix4_d;
  logic [IDXW-1:0]    idx_q, idx_d;

  logic               load_beat, clear_out, beat_done;
  logic [WIDTH-1:0]   src_m;
  logic               src_radix4;
  int                 src_idx;
  int                 ndig;

  logic [WIDTH:0]     ext;
  logic [1:0]         pair;
  logic [2:0]         win [LANES];
  booth_digit_t       dig [LANES];
  logic [LANES-1:0]   lane_en;
  logic [LANES-1:0]   beat_neg;
  logic [2*LANES-1:0] beat_mag;
  logic               beat_last;
  logic               skip;

  assign in_ready  = (state_q == ST_IDLE) | (out_ready & out_last);
  // a skipped beat never waits for the consumer
  assign beat_done = out_valid ? out_ready : 1'b1;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    radix4_d   = radix4_q;
    idx_d      = idx_q;
    load_beat  = 1'b0;
    clear_out  = 1'b0;
    src_m      = m_q;
    src_radix4 = radix4_q;
    src_idx    = int'(idx_q) + LANES;

    if ((state_q == ST_IDLE && in_valid) ||
        (state_q == ST_RUN && beat_done && out_last && in_valid)) begin
      state_d    = ST_RUN;
      m_d        = in_m;
      radix4_d   = in_radix4;
      idx_d      = '0;
      src_m      = in_m;
      src_radix4 = in_radix4;
      src_idx    = 0;
      load_beat  = 1'b1;
    end else if (state_q == ST_RUN && beat_done) begin
      if (out_last) begin
        state_d   = ST_IDLE;
        clear_out = 1'b1;
      end else begin
        idx_d     = IDXW'(src_idx);
        load_beat = 1'b1;
      end
    end
  end

  assign ndig      = digit_count(WIDTH, src_radix4);
  assign beat_last = (src_idx + LANES) >= ndig;

  // radix-2 digit i reuses the radix-4 encoder with window {m[i], m[i], m[i-1]}
  always_comb begin
    ext  = {src_m, 1'b0};
    pair = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = (src_idx + k) < ndig;
      pair       = 2'(ext >> (src_idx + k));
      if (src_radix4) win[k] = 3'(ext >> (2 * (src_idx + k)));
      else            win[k] = {pair[1], pair};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    booth_digit_enc u_enc (
      .win   (win[k]),
      .digit (dig[k])
    );
  end

  always_comb begin
    beat_neg = '0;
    beat_mag = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k]) begin
        beat_neg[k]         = dig[k].neg;
        beat_mag[2*k +: 2]  = dig[k].mag;
      end
    end
  end

`ifdef ZERO_SKIP_EN
  assign skip = ~(|beat_mag) & ~beat_last;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      radix4_q    <= 1'b0;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_neg     <= '0;
      out_mag     <= '0;
      out_lane_en <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      radix4_q <= radix4_d;
      idx_q    <= idx_d;
      if (load_beat) begin
        out_valid   <= ~skip;
        out_neg     <= beat_neg;
        out_mag     <= beat_mag;
        out_lane_en <= lane_en;
        out_idx     <= IDXW'(src_idx);
        out_last    <= beat_last;
      end else if (clear_out) begin
        out_valid   <= 1'b0;
        out_neg     <= '0;
        out_mag     <= '0;
        out_lane_en <= '0;
        out_idx     <= '0;
        out_last    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_digit_streamer.sv
// Scoreboard bench for booth_digit_streamer at WIDTH=8, LANES=4.
module tb_booth_digit_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_m = '0;
  logic       in_radix4 = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_neg;
  logic [7:0] out_mag;
  logic [3:0] out_lane_en;
  logic [2:0] out_idx;
  logic       out_last;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] neg;
    logic [7:0] mag;
    logic [3:0] en;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t sb[$];

  booth_digit_streamer #(.WIDTH(8), .LANES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_m        (in_m),
    .in_radix4   (in_radix4),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_neg     (out_neg),
    .out_mag     (out_mag),
    .out_lane_en (out_lane_en),
    .out_idx     (out_idx),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] neg, input logic [7:0] mag,
                      input logic [2:0] idx, input logic last);
    beat_t b;
    b.neg = neg; b.mag = mag; b.en = 4'hF; b.idx = idx; b.last = last;
    sb.push_back(b);
  endtask

  // monitor: every beat the consumer takes is compared with the scoreboard head
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat_idx", {29'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_neg",  {28'd0, out_neg},     {28'd0, e.neg});
        chk("beat_mag",  {24'd0, out_mag},     {24'd0, e.mag});
        chk("beat_en",   {28'd0, out_lane_en}, {28'd0, e.en});
        chk("beat_idx",  {29'd0, out_idx},     {29'd0, e.idx});
        chk("beat_last", {31'd0, out_last},    {31'd0, e.last});
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic r4, output int waited);
    waited = 0;
    in_valid = 1'b1; in_m = m; in_radix4 = r4;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_mag",   {24'd0, out_mag},   32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // radix-2, m=6: digits 0,-1,0,+1 then all zero
    push(4'b0010, 8'h44, 3'd0, 1'b0);
    push(4'b0000, 8'h00, 3'd4, 1'b1);
    send(8'h06, 1'b0, w);
    drain();

    // radix-4, m=6: digits -2,+2,0,0
    push(4'b0001, 8'h0A, 3'd0, 1'b1);
    send(8'h06, 1'b1, w);
    drain();

    // radix-2, m=-1: only digit 0 is -1
    push(4'b0001, 8'h01, 3'd0, 1'b0);
    push(4'b0000, 8'h00, 3'd4, 1'b1);
    send(8'hFF, 1'b0, w);
    drain();

    // backpressure on beat 0, then back-to-back radix-4 m=0x7F (-1,0,0,+2)
    out_ready = 1'b0;
    push(4'b0001, 8'h11, 3'd0, 1'b0);
    push(4'b0000, 8'h00, 3'd4, 1'b1);
    push(4'b0001, 8'h81, 3'd0, 1'b1);
    send(8'h03, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_mag",   {24'd0, out_mag},   32'h11);
      chk("bp_neg",   {28'd0, out_neg},   32'h1);
      chk("bp_idx",   {29'd0, out_idx},   32'd0);
      chk("bp_last",  {31'd0, out_last},  32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h7F, 1'b1, w);
    chk("b2b_wait_cycles", w, 32'd1);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_idx",   {29'd0, out_idx},   32'd0);
    drain();

    // m=-128 radix-2: only digit 7 is nonzero
`ifdef ZERO_SKIP_EN
    push(4'b1000, 8'h40, 3'd4, 1'b1);
`else
    push(4'b0000, 8'h00, 3'd0, 1'b0);
    push(4'b1000, 8'h40, 3'd4, 1'b1);
`endif
    send(8'h80, 1'b0, w);
    drain();

    // reset after beat 0 drops beat 1
    push(4'b0010, 8'h44, 3'd0, 1'b0);
    send(8'h06, 1'b0, w);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_mid_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_mid_neg",       {28'd0, out_neg},     32'd0);
    chk("rst_mid_mag",       {24'd0, out_mag},     32'd0);
    chk("rst_mid_en",        {28'd0, out_lane_en}, 32'd0);
    chk("rst_mid_idx",       {29'd0, out_idx},     32'd0);
    chk("rst_mid_last",      {31'd0, out_last},    32'd0);
    out_ready = 1'b1;
    push(4'b0001, 8'h0A, 3'd0, 1'b1);
    send(8'h06, 1'b1, w);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_run", {31'd0, out_valid}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_digit_streamer.md
# booth_digit_streamer

Sequential, parametrised Booth recoder for the DMAC datapath. It accepts one two's-complement multiplier operand over a valid/ready handshake and emits its Booth digits, LANES digits per beat, to the partial-product stage. It supports radix-2 and radix-4 recoding per operand and tolerates backpressure. It replaces the fixed 64-bit single-radix combinational recoder.

## Interface
- WIDTH, 64: operand width; must be even and at least 4.
- LANES, 4: digits per output beat; must be at least 1.
- IDXW, $clog2(WIDTH): width of the digit index.
- clk, input, 1: the only clock.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: operand offered.
- in_ready, output, 1: block can take an operand.
- in_m, input, WIDTH: multiplier operand, signed.
- in_radix4, input, 1: 1 selects radix-4, 0 selects radix-2; sampled with the operand.
- out_valid, output, 1: beat valid.
- out_ready, input, 1: consumer takes the beat.
- out_neg, output, LANES: per-lane sign of the digit.
- out_mag, output, 2*LANES: per-lane magnitude. 00 is 0, 01 is 1, 10 is 2; 11 is never driven.
- out_lane_en, output, LANES: lane holds a real digit; 0 marks padding past the last digit.
- out_idx, output, IDXW: digit index of lane 0.
- out_last, output, 1: final beat of the operand.

## Operation
- **Implicit bit.** The recoder appends m[-1] = 0 below the LSB.
- **Radix-2 digits.** There are WIDTH digits. Digit i = m[i-1] - m[i], so (0,0) gives 0, (0,1) gives +1, (1,0) gives -1, (1,1) gives 0, where the pair is (m[i], m[i-1]).
- **Radix-4 digits.** There are WIDTH/2 digits. Digit j = -2·m[2j+1] + m[2j] + m[2j-1], with a range of -2..+2.
- **Zero encoding.** A zero digit always has neg = 0 and mag = 00.
- **Beat order.** Lane k of a beat carries digit out_idx + k. Beats run from the least significant digit upward.
- **Beat count.** The number of beats is ceil(digits/LANES).
- **Padding lanes.** Lanes past the last digit have lane_en = 0 and carry the zero encoding.
- **State machine.** There are two states.
  - IDLE: in_ready = 1. When in_valid & in_ready, capture the operand and radix, set idx = 0, and go to RUN.
  - RUN: out_valid = 1. On out_valid & out_ready, advance idx by LANES. If out_last is set, return to IDLE.
- **Back-to-back operands.** In RUN, in_ready = out_ready & out_last. When a new operand is accepted in the same cycle the last beat is taken, the block stays in RUN with idx = 0 and the new operand, so there is no bubble.
- **Backpressure.** While out_valid & !out_ready, every out_* signal holds stable.
- **Arithmetic invariant.** The sum of digit_i · R^i equals the signed value of in_m, where R is 2 or 4.
- **Reset.** Reset forces IDLE, in_ready = 1 and out_valid = 0. All out_* data outputs reset to 0, and the held operand is cleared. This applies mid-operation as well: any beats not yet sent are dropped.

## Timing
- When an operand is accepted at edge t, the first beat is valid in the cycle after t.
- Throughput is one beat per cycle when there is no backpressure.
- Outputs are registered. Digits are computed combinationally from the held operand and idx, then registered.
- in_ready is a combinational function of the state, out_ready and out_last.

## Configuration
- **ZERO_SKIP_EN defined:** in RUN, any non-last beat whose enabled digits are all zero is suppressed internally. idx advances in one cycle without asserting out_valid. The last beat is always emitted, even when all its digits are zero.
- **ZERO_SKIP_EN undefined:** every beat is emitted, and the beat count is exactly ceil(digits/LANES).

## Structure
- **Package booth_pkg** holds:
  - the digit typedef (a struct with neg and mag[1:0]);
  - the magnitude constants MAG_ZERO, MAG_ONE and MAG_TWO;
  - the state enum ST_IDLE and ST_RUN;
  - a function computing the digit count from WIDTH and the radix.
- **Sub-module booth_digit_enc** is a combinational 3-bit-window to digit encoder. It is instantiated LANES times, and radix-2 uses it with a degenerate window.

## Test plan
All tests use WIDTH=8 and LANES=4.
- **Radix-2, m=6.** Input m=8'h06, radix-2 → two beats. The first beat has idx 0 with digits 0, -1, 0, +1. The second beat has idx 4 with all digits 0 and out_last.
- **Radix-4, m=6.** Input m=8'h06, radix-4 → one beat with digits -2, +2, 0, 0, all lanes enabled, and out_last.
- **Radix-2, m=-1.** Input m=8'hFF, radix-2 → digit 0 is -1 and the rest are 0. The zero encoding always has neg = 0.
- **Backpressure and back-to-back.** Hold out_ready low for 3 cycles during beat 0 → outputs are stable for those cycles. Then offer a second operand together with the last beat → it is accepted in the same cycle and beat 0 of the new operand follows on the next cycle.
- **Zero skip, m=-128.** Input m=8'h80, radix-2. With ZERO_SKIP_EN → a single beat with idx 4, digit 7 = -1 and out_last. Without ZERO_SKIP_EN → two beats.
- **Reset mid-operation.** Assert reset after beat 0 → the next cycle has out_valid = 0, in_ready = 1 and all out_* = 0. A new operand then starts at idx 0.
